arm_code_emitter: RTL and testbench
===================================

Name: arm_code_emitter

Overview:
- Downstream consumer of the translator's ARM instruction stream. The translator produces either push immediates or link-list ROM expansions.
- Buffers 32-bit ARM words in a small FIFO and writes them sequentially into code RAM starting at a base address.
- On a flush request, drains the FIFO, appends the return instruction BX LR (E12FFF1E), then reports completion and the emitted word count.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 10, code RAM word-address width.
- LIMIT, 1023, last writable word address (inclusive).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  translator has a valid ARM word on data
- data  in  32  ARM instruction word
- ready  out  1  emitter can accept a word this cycle
- base_addr  in  ADDR_W  first code RAM address; sampled in IDLE
- flush  in  1  end-of-method request; single-cycle pulse
- mem_we  out  1  write request to code RAM
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  write data
- mem_ack  in  1  code RAM accepted the write this cycle
- done  out  1  one-cycle pulse; method image complete
- word_count  out  ADDR_W+1  words written, including the terminator
- overflow  out  1  sticky; code RAM limit exceeded

Behaviour:
- Reset outputs: ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, word_count=0, overflow=0. FIFO is emptied; state is IDLE.
- States: IDLE, RUN, DRAIN, TERM, DONE.
- IDLE:
  - ready=0.
  - Next cycle goes to RUN and loads the address register from base_addr; word_count is cleared.
  - flush seen in IDLE is ignored.
- RUN:
  - ready = !full.
  - Push happens when start&&ready; data is captured at that edge.
  - start while full is a protocol error; the word is dropped and the FIFO is unchanged.
  - Simultaneous push and pop is allowed when full; the pop frees the slot the same cycle.
  - flush in RUN goes to DRAIN. A start in the same cycle as flush is still accepted.
- Write port:
  - mem_we = !empty && !overflow, in RUN and DRAIN.
  - mem_wdata is the FIFO head; mem_addr is the address register.
  - mem_we, mem_addr and mem_wdata hold stable until mem_ack.
  - On mem_we&&mem_ack: pop, increment the address, increment word_count.
  - mem_ack without mem_we is ignored.
  - Minimum latency from accepted push to mem_we is 1 cycle. With mem_ack tied high, throughput is 1 word/cycle.
- DRAIN:
  - ready=0.
  - When the FIFO is empty (or overflow is set), go to TERM.
- TERM:
  - mem_we=1, mem_wdata=E12FFF1E.
  - On mem_ack: increment word_count, go to DONE.
  - If overflow is set, skip the write and go straight to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - word_count and overflow hold until the next IDLE→RUN transition.
- Overflow:
  - Set instead of performing any write whose address is greater than LIMIT.
  - Once set: no further mem_we, remaining FIFO entries are discarded, ready stays 1 in RUN (input is swallowed), and flush still completes to DONE.
  - The address register never wraps.
- Reset mid-operation returns to the reset state immediately; partial images are abandoned.

Test Plan:
- Basic stream:
  - Stimulus: base_addr=0x010, mem_ack=1; push E3A00005, E52D0004; flush.
  - Required: writes 0x010=E3A00005, 0x011=E52D0004, 0x012=E12FFF1E; done pulses once; word_count=3.
- Backpressure:
  - Stimulus: mem_ack=0, push 4 words.
  - Required: ready drops after the 4th push; mem_we, mem_addr and mem_wdata hold the first word.
  - Then: release mem_ack. Required: words written in order at consecutive addresses; ready returns after the first ack.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, start and mem_ack in the same cycle.
  - Required: occupancy stays 4; no word lost or duplicated.
- Overflow:
  - Stimulus: base_addr=LIMIT-1, push 3 words, flush.
  - Required: only LIMIT-1 and LIMIT are written; overflow=1; no terminator written; done still pulses; word_count=2.
- Flush on empty FIFO:
  - Stimulus: flush right after entering RUN.
  - Required: single write of E12FFF1E at base_addr; word_count=1.
- Mid-operation reset:
  - Stimulus: assert reset with 3 words buffered and mem_ack=0.
  - Required: next cycle mem_we=0, ready=0, word_count=0. After release, the next image starts from the newly sampled base_addr.

Source files
------------

// File: rtl/arm_code_emitter.sv
// Buffers translated ARM words in a small FIFO and writes them sequentially into code RAM,
// closing each method image with BX LR and reporting the emitted word count.
module arm_code_emitter #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10,
    parameter int LIMIT  = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       data,
    output logic              ready,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              flush,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [31:0]     BX_LR   = 32'hE12FFF1E;
    localparam logic [ADDR_W:0] LIMIT_A = (ADDR_W + 1)'(LIMIT);
    localparam logic [PTR_W:0]  FULL_N  = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, TERM, DONE} state_t;

    state_t            state;
    logic [31:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    // One bit wider than the RAM address so the pointer never wraps past LIMIT.
    logic [ADDR_W:0]   addr;

    logic empty;
    logic full;
    logic in_range;
    logic streaming;
    logic term_wr;
    logic pop;
    logic push;

    assign empty     = (count == '0);
    assign full      = (count == FULL_N);
    assign in_range  = (addr <= LIMIT_A);
    assign streaming = ((state == RUN) || (state == DRAIN)) && !empty && !overflow;
    assign term_wr   = (state == TERM) && !overflow && in_range;

    assign mem_we    = (streaming && in_range) || term_wr;
    assign mem_addr  = addr[ADDR_W-1:0];
    assign mem_wdata = term_wr ? BX_LR : (mem_we ? fifo_mem[rd_ptr] : 32'h0);
    assign done      = (state == DONE);

    // After overflow, input is swallowed so the translator never stalls.
    assign ready = (state == RUN) && (!full || overflow);
    assign pop   = streaming && in_range && mem_ack;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push  = (state == RUN) && start && !overflow && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            addr       <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                addr       <= addr + (ADDR_W + 1)'(1);
                word_count <= word_count + (ADDR_W + 1)'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W + 1)'(1);
            end
            // Out-of-range write: flag it and discard everything still buffered.
            if (streaming && !in_range) begin
                overflow <= 1'b1;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end

            case (state)
                IDLE: begin
                    addr       <= {1'b0, base_addr};
                    word_count <= '0;
                    overflow   <= 1'b0;
                    count      <= '0;
                    wr_ptr     <= '0;
                    rd_ptr     <= '0;
                    state      <= RUN;
                end
                RUN: begin
                    if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty || overflow) begin
                        state <= TERM;
                    end
                end
                TERM: begin
                    if (!term_wr) begin
                        overflow <= 1'b1;
                        state    <= DONE;
                    end else if (mem_ack) begin
                        word_count <= word_count + (ADDR_W + 1)'(1);
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_code_emitter.sv
// Bench for arm_code_emitter: an expected-write list built from the image rules is
// checked against every RAM write, plus literal checks on each scenario.
module tb_arm_code_emitter;

    localparam int ADDR_W = 10;
    localparam int LIMIT  = 1023;
    localparam int DEPTH  = 4;
    localparam logic [31:0] TERM_W = 32'hE12FFF1E;

    logic              clk;
    logic              reset;
    logic              start;
    logic [31:0]       data;
    logic              ready;
    logic [ADDR_W-1:0] base_addr;
    logic              flush;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic              done;
    logic [ADDR_W:0]   word_count;
    logic              overflow;

    arm_code_emitter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .start(start), .data(data), .ready(ready),
        .base_addr(base_addr), .flush(flush), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .done(done),
        .word_count(word_count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [ADDR_W:0] a;
        logic [31:0]     d;
    } wr_t;

    wr_t             exp_q[$];
    wr_t             wlog[$];
    logic [31:0]     img[$];
    int              exp_wc;
    logic            exp_ovf;
    int              done_cnt = 0;
    logic [ADDR_W:0] wc_at_done;
    logic            ovf_at_done;

    // Model: image words land at base, base+1, ...; the first address beyond LIMIT
    // ends the image with overflow, otherwise BX LR follows the last word.
    task automatic expect_image(input int base);
        int  a;
        wr_t e;
        a = base;
        exp_ovf = 1'b0;
        exp_wc  = 0;
        exp_q.delete();
        wlog.delete();
        foreach (img[i]) begin
            if (!exp_ovf) begin
                if (a > LIMIT) begin
                    exp_ovf = 1'b1;
                end else begin
                    e.a = a[ADDR_W:0];
                    e.d = img[i];
                    exp_q.push_back(e);
                    exp_wc++;
                    a++;
                end
            end
        end
        if (!exp_ovf) begin
            if (a > LIMIT) begin
                exp_ovf = 1'b1;
            end else begin
                e.a = a[ADDR_W:0];
                e.d = TERM_W;
                exp_q.push_back(e);
                exp_wc++;
            end
        end
    endtask

    logic              hold = 1'b0;
    logic [ADDR_W-1:0] hold_a;
    logic [31:0]       hold_d;
    logic              prev_done = 1'b0;
    wr_t               got;
    wr_t               want;

    always @(negedge clk) begin
        if (reset) begin
            hold      = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (hold) begin
                check("hold_we", mem_we, 1'b1);
                check("hold_addr", mem_addr, hold_a);
                check("hold_data", mem_wdata, hold_d);
            end
            if (mem_we && mem_ack) begin
                got.a = {1'b0, mem_addr};
                got.d = mem_wdata;
                wlog.push_back(got);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_write: addr %0h data %0h, expected no write", mem_addr, mem_wdata);
                end else begin
                    want = exp_q.pop_front();
                    check("wr_addr", got.a, want.a);
                    check("wr_data", got.d, want.d);
                end
            end
            hold   = mem_we && !mem_ack;
            hold_a = mem_addr;
            hold_d = mem_wdata;
            if (prev_done) begin
                check("done_width", done, 1'b0);
            end
            if (done) begin
                done_cnt++;
                wc_at_done  = word_count;
                ovf_at_done = overflow;
                check("done_wc", word_count, exp_wc);
                check("done_ovf", overflow, exp_ovf);
                check("done_pending", exp_q.size(), 0);
            end
            prev_done = done;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        int t;
        t = 0;
        start = 1'b1;
        data  = w;
        @(negedge clk);
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ready) check("push_timeout", ready, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_flush;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_done;
        int t;
        t = 0;
        @(negedge clk);
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!done) check("done_timeout", done, 1'b1);
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; data = '0; base_addr = '0; flush = 1'b0; mem_ack = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_ready", ready, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_done", done, 1'b0);
        check("rst_wc", word_count, 0);
        check("rst_ovf", overflow, 1'b0);

        // Basic stream; the flush pulse during IDLE must be ignored.
        img = '{32'hE3A00005, 32'hE52D0004};
        expect_image(12'h010);
        base_addr = 10'h010;
        mem_ack   = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        push(img[0]);
        push(img[1]);
        pulse_flush();
        wait_done();
        check("basic_nwr", wlog.size(), 3);
        check("basic_w0", {wlog[0].a, wlog[0].d}, {11'h010, 32'hE3A00005});
        check("basic_w1", {wlog[1].a, wlog[1].d}, {11'h011, 32'hE52D0004});
        check("basic_w2", {wlog[2].a, wlog[2].d}, {11'h012, 32'hE12FFF1E});
        check("basic_wc", wc_at_done, 3);
        check("basic_done_cnt", done_cnt, 1);

        // Backpressure, plus a start while full that must be dropped.
        img = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        expect_image(12'h100);
        base_addr = 10'h100;
        mem_ack   = 1'b0;
        tick();
        foreach (img[i]) push(img[i]);
        @(negedge clk);
        check("bp_ready_full", ready, 1'b0);
        check("bp_we", mem_we, 1'b1);
        check("bp_addr", mem_addr, 10'h100);
        check("bp_data", mem_wdata, 32'h11111111);
        start = 1'b1;
        data  = 32'hDEADBEEF;
        tick();
        start = 1'b0;
        repeat (2) tick();
        mem_ack = 1'b1;
        tick();
        @(negedge clk);
        check("bp_ready_after_ack", ready, 1'b1);
        @(posedge clk); #1;
        pulse_flush();
        wait_done();
        check("bp_wc", wc_at_done, 5);

        // Full FIFO: push and pop in the same cycle.
        img = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'hA0000005};
        expect_image(12'h200);
        base_addr = 10'h200;
        mem_ack   = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) push(img[i]);
        start   = 1'b1;
        data    = img[4];
        mem_ack = 1'b1;
        tick();
        start   = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        check("pp_still_full", ready, 1'b0);
        check("pp_addr", mem_addr, 10'h201);
        check("pp_data", mem_wdata, 32'hA0000002);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        pulse_flush();
        wait_done();
        check("pp_wc", wc_at_done, 6);

        // Overflow at the top of code RAM.
        img = '{32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004};
        expect_image(LIMIT - 1);
        base_addr = 10'(LIMIT - 1);
        mem_ack   = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) push(img[i]);
        repeat (3) tick();
        @(negedge clk);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_ready", ready, 1'b1);
        @(posedge clk); #1;
        push(img[3]);
        pulse_flush();
        wait_done();
        check("ovf_wc", wc_at_done, 2);
        check("ovf_sticky", ovf_at_done, 1'b1);
        check("ovf_nwr", wlog.size(), 2);
        check("ovf_last_addr", wlog[1].a, 11'd1023);

        // Flush straight after entering RUN.
        img.delete();
        expect_image(12'h3F0);
        base_addr = 10'h3F0;
        tick();
        pulse_flush();
        wait_done();
        check("empty_w0", {wlog[0].a, wlog[0].d}, {11'h3F0, 32'hE12FFF1E});
        check("empty_wc", wc_at_done, 1);

        // Reset with words buffered, then a fresh image at a new base.
        img = '{32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004};
        expect_image(12'h050);
        base_addr = 10'h050;
        mem_ack   = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) push(img[i]);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        push(img[3]);
        @(negedge clk);
        check("mr_wc_before", word_count, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        tick();
        @(negedge clk);
        check("mr_we", mem_we, 1'b0);
        check("mr_ready", ready, 1'b0);
        check("mr_wc", word_count, 0);
        check("mr_done", done, 1'b0);
        img = '{32'hD0000001};
        expect_image(12'h060);
        base_addr = 10'h060;
        @(posedge clk); #1;
        reset   = 1'b0;
        mem_ack = 1'b1;
        tick();
        push(img[0]);
        pulse_flush();
        wait_done();
        check("mr_new_base", {wlog[0].a, wlog[0].d}, {11'h060, 32'hD0000001});
        check("mr_term", {wlog[1].a, wlog[1].d}, {11'h061, 32'hE12FFF1E});
        check("total_done_cnt", done_cnt, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
